// File: rtl/grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wb_arbiter
//   Shares the single GRF write port between two writeback sources.
//   Port 0 is the main pipeline WB stage and has fixed priority. Port 1 is the
//   multi-cycle MDU / long-latency unit. A starvation counter forces one grant
//   to port 1 after MAX_WAIT consecutive lost cycles. The grf_* outputs are
//   registered and drive the GRF WE/A3/WD/WPC pins directly.
//
// Parameters
//   MAX_WAIT  consecutive lost cycles on port 1 before a forced grant (1..15)
//   DW        write-data and PC width
//   AW        register address width
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous, active-high reset
//   wb0_valid  in   pipeline WB write request
//   wb0_ready  out  port 0 accepted this cycle (handshake = valid & ready)
//   wb0_a3     in   port 0 destination register
//   wb0_wd     in   port 0 write data
//   wb0_pc     in   port 0 instruction PC
//   wb1_valid  in   MDU write request, held with stable fields until ready
//   wb1_ready  out  port 1 accepted this cycle
//   wb1_a3     in   port 1 destination register
//   wb1_wd     in   port 1 write data
//   wb1_pc     in   port 1 instruction PC
//   grf_we     out  registered GRF write enable
//   grf_a3     out  registered GRF write address
//   grf_wd     out  registered GRF write data
//   grf_wpc    out  registered PC for the write trace
//   grf_src    out  registered source of the current write (0 = port 0)
//   wr_count   out  count of committed writes with a3 != 0 (wraps)
// -----------------------------------------------------------------------------
module grf_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb0_valid,
  output logic          wb0_ready,
  input  logic [AW-1:0] wb0_a3,
  input  logic [DW-1:0] wb0_wd,
  input  logic [DW-1:0] wb0_pc,
  input  logic          wb1_valid,
  output logic          wb1_ready,
  input  logic [AW-1:0] wb1_a3,
  input  logic [DW-1:0] wb1_wd,
  input  logic [DW-1:0] wb1_pc,
  output logic          grf_we,
  output logic [AW-1:0] grf_a3,
  output logic [DW-1:0] grf_wd,
  output logic [DW-1:0] grf_wpc,
  output logic          grf_src,
  output logic [31:0]   wr_count
);

  typedef enum logic {
    ST_PRIO  = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       hs0;
  logic       hs1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_PRIO;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_PRIO: begin
        if (wb0_valid && wb1_valid) begin
          // Port 1 lost this cycle; the last allowed loss arms the forced grant.
          if (cnt == CNT_LAST) begin
            state_nxt = ST_FORCE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else begin
          // Either port 1 was granted or it is not requesting.
          cnt_nxt = 4'd0;
        end
      end
      ST_FORCE: begin
        // One cycle only: port 1 is granted if valid, otherwise nothing is
        // accepted and priority returns to port 0.
        state_nxt = ST_PRIO;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = ST_PRIO;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: ready is a pure function of state, wb0_valid and reset, so
  // at most one handshake can occur per cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb0_ready = 1'b0;
    wb1_ready = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_PRIO: begin
          wb0_ready = 1'b1;
          wb1_ready = ~wb0_valid;
        end
        ST_FORCE: begin
          wb0_ready = 1'b0;
          wb1_ready = 1'b1;
        end
        default: begin
          wb0_ready = 1'b0;
          wb1_ready = 1'b0;
        end
      endcase
    end
  end

  assign hs0 = wb0_valid & wb0_ready;
  assign hs1 = wb1_valid & wb1_ready;

  // ---------------------------------------------------------------------------
  // Registered GRF write port and commit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we   <= 1'b0;
      grf_a3   <= '0;
      grf_wd   <= '0;
      grf_wpc  <= '0;
      grf_src  <= 1'b0;
      wr_count <= 32'd0;
    end else if (hs0) begin
      grf_we  <= (wb0_a3 != '0);
      grf_a3  <= wb0_a3;
      grf_wd  <= wb0_wd;
      grf_wpc <= wb0_pc;
      grf_src <= 1'b0;
      if (wb0_a3 != '0) begin
        wr_count <= wr_count + 32'd1;
      end
    end else if (hs1) begin
      grf_we  <= (wb1_a3 != '0);
      grf_a3  <= wb1_a3;
      grf_wd  <= wb1_wd;
      grf_wpc <= wb1_pc;
      grf_src <= 1'b1;
      if (wb1_a3 != '0) begin
        wr_count <= wr_count + 32'd1;
      end
    end else begin
      // Idle cycle: drop the enable, keep the last address/data for tracing.
      grf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grf_wb_arbiter
//   Directed, table-driven bench for grf_wb_arbiter (MAX_WAIT = 4). Each
//   vector drives one cycle of inputs on the falling edge, checks the
//   combinational ready outputs before the rising edge, then checks the
//   registered GRF outputs and wr_count just after the rising edge.
// -----------------------------------------------------------------------------
module tb_grf_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic          wb0_valid;
  logic          wb0_ready;
  logic [AW-1:0] wb0_a3;
  logic [DW-1:0] wb0_wd;
  logic [DW-1:0] wb0_pc;
  logic          wb1_valid;
  logic          wb1_ready;
  logic [AW-1:0] wb1_a3;
  logic [DW-1:0] wb1_wd;
  logic [DW-1:0] wb1_pc;
  logic          grf_we;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd;
  logic [DW-1:0] grf_wpc;
  logic          grf_src;
  logic [31:0]   wr_count;

  int unsigned n_pass;
  int unsigned n_total;

  grf_wb_arbiter #(
    .MAX_WAIT(4),
    .DW      (DW),
    .AW      (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb0_valid(wb0_valid),
    .wb0_ready(wb0_ready),
    .wb0_a3   (wb0_a3),
    .wb0_wd   (wb0_wd),
    .wb0_pc   (wb0_pc),
    .wb1_valid(wb1_valid),
    .wb1_ready(wb1_ready),
    .wb1_a3   (wb1_a3),
    .wb1_wd   (wb1_wd),
    .wb1_pc   (wb1_pc),
    .grf_we   (grf_we),
    .grf_a3   (grf_a3),
    .grf_wd   (grf_wd),
    .grf_wpc  (grf_wpc),
    .grf_src  (grf_src),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the expected response.
  typedef struct {
    logic          rst;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [DW-1:0] p0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [DW-1:0] p1;
    logic          r0;   // expected wb0_ready during the cycle
    logic          r1;   // expected wb1_ready during the cycle
    logic          we;   // expected registered outputs after the edge
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    logic [DW-1:0] wpc;
    logic          src;
    logic [31:0]   cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    reset     = v.rst;
    wb0_valid = v.v0;
    wb0_a3    = v.a0;
    wb0_wd    = v.d0;
    wb0_pc    = v.p0;
    wb1_valid = v.v1;
    wb1_a3    = v.a1;
    wb1_wd    = v.d1;
    wb1_pc    = v.p1;
    #1;
    check({tag, ".wb0_ready"}, 32'(wb0_ready), 32'(v.r0));
    check({tag, ".wb1_ready"}, 32'(wb1_ready), 32'(v.r1));
    @(posedge clk);
    #1;
    check({tag, ".grf_we"},   32'(grf_we),  32'(v.we));
    check({tag, ".grf_a3"},   32'(grf_a3),  32'(v.a3));
    check({tag, ".grf_wd"},   grf_wd,       v.wd);
    check({tag, ".grf_wpc"},  grf_wpc,      v.wpc);
    check({tag, ".grf_src"},  32'(grf_src), 32'(v.src));
    check({tag, ".wr_count"}, wr_count,     v.cnt);
  endtask

  // Conflict cycle used by the hand sequences: port 0 (a3=2) vs port 1 (a3=3).
  task automatic conflict(input string tag, input logic r0, input logic r1,
                          input logic src, input logic [31:0] cnt);
    vec_t v;
    v = '{1'b0, 1'b1, 5'd2, 32'h20, 32'h200, 1'b1, 5'd3, 32'h30, 32'h300,
          r0, r1, 1'b1, src ? 5'd3 : 5'd2, src ? 32'h30 : 32'h20,
          src ? 32'h300 : 32'h200, src, cnt};
    run_vec(tag, v);
  endtask

  vec_t tbl[$];

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    wb0_valid = 1'b0;
    wb0_a3    = '0;
    wb0_wd    = '0;
    wb0_pc    = '0;
    wb1_valid = 1'b0;
    wb1_a3    = '0;
    wb1_wd    = '0;
    wb1_pc    = '0;

    //          rst  v0  a0   d0           p0           v1  a1    d1        p1       r0 r1 we a3   wd           wpc          src cnt
    // Reset with a port 1 request pending: nothing is ready, outputs cleared.
    tbl.push_back('{1, 0, 0,  0,           0,           1,  4,    32'h44,   32'h440, 0, 0, 0, 0,   0,           0,           0,  0});
    tbl.push_back('{1, 1, 7,  32'h77,      32'h770,     1,  4,    32'h44,   32'h440, 0, 0, 0, 0,   0,           0,           0,  0});
    // Port 0 only.
    tbl.push_back('{0, 1, 5,  32'h1234,    32'h3000,    0,  0,    0,        0,       1, 0, 1, 5,   32'h1234,    32'h3000,    0,  1});
    // Idle: enable drops, address/data/pc hold.
    tbl.push_back('{0, 0, 0,  0,           0,           0,  0,    0,        0,       1, 1, 0, 5,   32'h1234,    32'h3000,    0,  1});
    // Port 1 only: ready in the same cycle.
    tbl.push_back('{0, 0, 0,  0,           0,           1,  8,    32'hCAFE, 32'h4000,1, 1, 1, 8,   32'hCAFE,    32'h4000,    1,  2});
    // Continuous conflict: port 0 wins cycles 0-3, FORCE grants port 1, then PRIO.
    tbl.push_back('{0, 1, 1,  32'h10,      32'h100,     1,  9,    32'h99,   32'h900, 1, 0, 1, 1,   32'h10,      32'h100,     0,  3});
    tbl.push_back('{0, 1, 2,  32'h11,      32'h104,     1,  9,    32'h99,   32'h900, 1, 0, 1, 2,   32'h11,      32'h104,     0,  4});
    tbl.push_back('{0, 1, 3,  32'h12,      32'h108,     1,  9,    32'h99,   32'h900, 1, 0, 1, 3,   32'h12,      32'h108,     0,  5});
    tbl.push_back('{0, 1, 4,  32'h13,      32'h10C,     1,  9,    32'h99,   32'h900, 1, 0, 1, 4,   32'h13,      32'h10C,     0,  6});
    tbl.push_back('{0, 1, 5,  32'h14,      32'h110,     1,  9,    32'h99,   32'h900, 0, 1, 1, 9,   32'h99,      32'h900,     1,  7});
    tbl.push_back('{0, 1, 6,  32'h15,      32'h114,     1,  10,   32'hAA,   32'hA00, 1, 0, 1, 6,   32'h15,      32'h114,     0,  8});
    // Idle clears the starvation counter (port 1 not requesting).
    tbl.push_back('{0, 0, 0,  0,           0,           0,  0,    0,        0,       1, 1, 0, 6,   32'h15,      32'h114,     0,  8});
    // Port 1 with a3 = 0: consumed, fields latched, no write committed.
    tbl.push_back('{0, 0, 0,  0,           0,           1,  0,    32'hFFFF, 32'h500, 1, 1, 0, 0,   32'hFFFF,    32'h500,     1,  8});
    // Port 0 at the top register with extreme data/pc values.
    tbl.push_back('{0, 1, 31, 32'hDEADBEEF,32'hFFFFFFFC,0,  0,    0,        0,       1, 0, 1, 31,  32'hDEADBEEF,32'hFFFFFFFC,0,  9});

    foreach (tbl[i]) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // FORCE with wb1_valid low: nothing accepted, outputs hold, PRIO resumes.
    conflict("viol_c0", 1, 0, 0, 10);
    conflict("viol_c1", 1, 0, 0, 11);
    conflict("viol_c2", 1, 0, 0, 12);
    conflict("viol_c3", 1, 0, 0, 13);
    run_vec("viol_force", '{0, 1, 7, 32'h70, 32'h700, 0, 0, 0, 0,
                             0, 1, 0, 2, 32'h20, 32'h200, 0, 13});
    run_vec("viol_prio",  '{0, 1, 7, 32'h70, 32'h700, 0, 0, 0, 0,
                             1, 0, 1, 7, 32'h70, 32'h700, 0, 14});

    // Reset asserted while in FORCE with port 1 requesting.
    conflict("rst_c0", 1, 0, 0, 15);
    conflict("rst_c1", 1, 0, 0, 16);
    conflict("rst_c2", 1, 0, 0, 17);
    conflict("rst_c3", 1, 0, 0, 18);
    run_vec("rst_force", '{1, 1, 2, 32'h20, 32'h200, 1, 3, 32'h30, 32'h300,
                            0, 0, 0, 0, 0, 0, 0, 0});
    // After reset the counter restarts: four full losses before FORCE again.
    conflict("post_c0", 1, 0, 0, 1);
    conflict("post_c1", 1, 0, 0, 2);
    conflict("post_c2", 1, 0, 0, 3);
    conflict("post_c3", 1, 0, 0, 4);
    conflict("post_force", 0, 1, 1, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
